sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single-port 8-bit SRAM between two requesters: the JTAG host port and the downscaling engine port.
- The JTAG host port is the connect front-end's memory interface, already re-timed into the clk domain upstream.
- Grants at most one access per cycle and routes the 1-cycle read data back to the requester that issued the read.
- Enforces step mode: the engine gets one memory access per step_pulse.

Parameters:
ADDR_BITS, 8, SRAM address width
DATA_BITS, 8, SRAM data width
HOST_PRIORITY, 1, 1 = host fixed priority with starvation guard; 0 = round-robin
STARVE_LIMIT, 4, consecutive lost contended cycles after which the engine wins once (HOST_PRIORITY=1 only)

Ports:
clk  in  1  system clock (CLOCK_50 at top)
reset_n  in  1  asynchronous active-low reset
h_req  in  1  host access request
h_we  in  1  host write enable (0 = read)
h_addr  in  ADDR_BITS  host address
h_wdata  in  DATA_BITS  host write data
h_gnt  out  1  host access accepted this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_BITS  host read data
p_req  in  1  engine access request
p_we  in  1  engine write enable
p_addr  in  ADDR_BITS  engine address
p_wdata  in  DATA_BITS  engine write data
p_gnt  out  1  engine access accepted this cycle
p_rvalid  out  1  engine read data valid
p_rdata  out  DATA_BITS  engine read data
step_mode  in  1  1 = engine gated by step credits
step_pulse  in  1  one-cycle step strobe (clk domain)
step_overrun  out  1  one-cycle pulse: step_pulse arrived while credit already held
p_stalled  out  1  engine requesting but blocked (no credit, or lost arbitration)
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_BITS  SRAM address
mem_data_in  out  DATA_BITS  SRAM write data
mem_data_out  in  DATA_BITS  SRAM read data, valid the cycle after the address

Behaviour:
- Reset values (all outputs while reset_n=0): gnt 0, rvalid 0, step_overrun 0, p_stalled 0, mem_we 0, mem_addr 0, mem_data_in 0. Internally: credit 0, starve count 0, last-grant pointer = engine, read tag cleared.
- Handshake: requester holds req/we/addr/wdata stable until gnt. gnt is combinational in the request cycle and lasts one cycle per access. Holding req high gives back-to-back accesses.
- Engine eligibility: p_elig = p_req & (~step_mode | credit).
- Arbitration with only one eligible requester: it wins.
- Arbitration with both eligible:
  - HOST_PRIORITY=1: host wins unless starve count == STARVE_LIMIT, then engine wins.
  - HOST_PRIORITY=0: winner is the requester not granted last.
- Starve count: increments on each contended cycle the engine loses; clears on any engine grant; saturates at STARVE_LIMIT.
- Last-grant pointer updates on every grant.
- Memory mux: mem_addr, mem_data_in and mem_we (= winner.we) come from the winner. With no winner: mem_we=0, mem_addr=0, mem_data_in=0.
- Read return, fixed 1-cycle latency: a granted read at cycle N gives rvalid at N+1 on that requester's port only. rdata is driven from mem_data_out and is don't-care when rvalid=0. Writes produce no rvalid.
- Step FSM, states OFF / ARMED / EMPTY:
  - OFF: step_mode=0, credit unused. Goes to EMPTY when step_mode rises.
  - EMPTY: goes to ARMED on step_pulse.
  - ARMED: on engine grant, goes to EMPTY, or stays ARMED if step_pulse is in the same cycle. A step_pulse with no grant stays ARMED and pulses step_overrun. Credits never accumulate beyond 1.
  - Any state: goes to OFF when step_mode falls; pending credit is discarded.
- Host is never gated by step mode.
- p_stalled = p_req & ~p_gnt, registered-free (combinational).
- Asynchronous reset mid-operation: a pending read tag is discarded. No rvalid after reset release for pre-reset reads.
- No combinational path from gnt back into req is assumed. Requesters must not make req depend on gnt in the same cycle.

Decomposition:
- Package sram_arb_pkg: requester enum {REQ_HOST, REQ_ENG}, step state enum {STEP_OFF, STEP_EMPTY, STEP_ARMED}, default width constants.
- One sub-module, step_credit_gate: owns the step FSM and produces credit and step_overrun.
- Arbitration, mux and read tag stay in the top of the block.

Test Plan:
- Host write addr 0x10 data 0xA5, then host read 0x10 → h_gnt on each request cycle; h_rvalid one cycle after the read with h_rdata=0xA5; p_rvalid stays 0.
- HOST_PRIORITY=1, both request reads continuously → host granted 4 cycles, engine on cycle 5, repeating (STARVE_LIMIT=4).
- HOST_PRIORITY=0, both request continuously → grants alternate host/engine each cycle; each rvalid lands on the matching port.
- step_mode=1, p_req held high, no pulse for 10 cycles → p_gnt=0 and p_stalled=1.
- step_mode=1, p_req held high, then one step_pulse → exactly one p_gnt; step_pulse twice in EMPTY with no p_req → step_overrun=1 on the second pulse.
- Engine read granted, then reset_n dropped the next cycle → p_rvalid stays 0; all outputs at reset values; clean grant after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_BITS_DEF = 8;
    localparam int unsigned DATA_BITS_DEF = 8;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_ENG  = 1'b1
    } req_t;

    typedef enum logic [1:0] {
        STEP_OFF   = 2'd0,
        STEP_EMPTY = 2'd1,
        STEP_ARMED = 2'd2
    } step_state_t;

endpackage

// File: rtl/sram_port_arbiter_step_credit_gate.sv
// Step-mode credit FSM: one engine access per step_pulse, credit never exceeds one.
module step_credit_gate
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic step_mode,
    input  logic step_pulse,
    input  logic eng_gnt,
    output logic credit_c,
    output logic overrun_c
);

    step_state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= STEP_OFF;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        overrun_c = 1'b0;
        case (state_q)
            STEP_OFF:   if (step_mode) state_d = STEP_EMPTY;
            STEP_EMPTY: if (step_pulse) state_d = STEP_ARMED;
            STEP_ARMED: begin
                if (eng_gnt && !step_pulse)      state_d = STEP_EMPTY;
                else if (!eng_gnt && step_pulse) overrun_c = 1'b1;
            end
            default:    state_d = STEP_OFF;
        endcase
        // Leaving step mode discards any held credit.
        if (state_q != STEP_OFF && !step_mode) begin
            state_d   = STEP_OFF;
            overrun_c = 1'b0;
        end
    end

    assign credit_c = (state_q == STEP_ARMED);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for the single-port SRAM: host vs. downscaling engine,
// with step-mode gating of the engine and 1-cycle read-data return routing.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = ADDR_BITS_DEF,
    parameter int unsigned DATA_BITS     = DATA_BITS_DEF,
    parameter int unsigned HOST_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [ADDR_BITS-1:0] h_addr,
    input  logic [DATA_BITS-1:0] h_wdata,
    output logic                 h_gnt,
    output logic                 h_rvalid,
    output logic [DATA_BITS-1:0] h_rdata,
    input  logic                 p_req,
    input  logic                 p_we,
    input  logic [ADDR_BITS-1:0] p_addr,
    input  logic [DATA_BITS-1:0] p_wdata,
    output logic                 p_gnt,
    output logic                 p_rvalid,
    output logic [DATA_BITS-1:0] p_rdata,
    input  logic                 step_mode,
    input  logic                 step_pulse,
    output logic                 step_overrun,
    output logic                 p_stalled,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_data_in,
    input  logic [DATA_BITS-1:0] mem_data_out
);

    localparam int unsigned STARVE_BITS = $clog2(STARVE_LIMIT + 1);

    logic                   credit;
    logic                   overrun;
    logic                   h_elig;
    logic                   p_elig;
    logic                   contended;
    logic                   eng_wins;
    req_t                   last_q;
    logic [STARVE_BITS-1:0] starve_q;
    logic                   tag_valid_q;
    req_t                   tag_who_q;

    step_credit_gate u_step (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_mode  (step_mode),
        .step_pulse (step_pulse),
        .eng_gnt    (p_gnt),
        .credit_c   (credit),
        .overrun_c  (overrun)
    );

    // Arbitration and memory mux; requests are masked while in reset.
    always_comb begin
        h_elig    = h_req & reset_n;
        p_elig    = p_req & reset_n & (~step_mode | credit);
        contended = h_elig & p_elig;
        if (HOST_PRIORITY != 0) eng_wins = (starve_q == STARVE_BITS'(STARVE_LIMIT));
        else                    eng_wins = (last_q == REQ_HOST);
        h_gnt       = h_elig & ~(p_elig & eng_wins);
        p_gnt       = p_elig & ~(h_elig & ~eng_wins);
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (h_gnt) begin
            mem_we      = h_we;
            mem_addr    = h_addr;
            mem_data_in = h_wdata;
        end else if (p_gnt) begin
            mem_we      = p_we;
            mem_addr    = p_addr;
            mem_data_in = p_wdata;
        end
        p_stalled = p_req & ~p_gnt & reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= REQ_ENG;
            starve_q    <= '0;
            tag_valid_q <= 1'b0;
            tag_who_q   <= REQ_HOST;
        end else begin
            if (h_gnt)      last_q <= REQ_HOST;
            else if (p_gnt) last_q <= REQ_ENG;
            if (p_gnt)
                starve_q <= '0;
            else if (contended && starve_q != STARVE_BITS'(STARVE_LIMIT))
                starve_q <= starve_q + STARVE_BITS'(1);
            tag_valid_q <= (h_gnt & ~h_we) | (p_gnt & ~p_we);
            tag_who_q   <= p_gnt ? REQ_ENG : REQ_HOST;
        end
    end

    assign h_rvalid     = tag_valid_q & (tag_who_q == REQ_HOST);
    assign p_rvalid     = tag_valid_q & (tag_who_q == REQ_ENG);
    assign h_rdata      = mem_data_out;
    assign p_rdata      = mem_data_out;
    assign step_overrun = overrun;

endmodule
